// File: rtl/eth_stats_counter.sv
// Passive TX/RX frame monitor producing 64-bit byte/good/bad counters; commit latency 1 cycle after last beat.
// Never backpressures: valid/ready are only observed, and a beat is valid & ready.
module eth_stats_dir #(
  parameter int len_width = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        valid,
  input  logic        ready,
  input  logic        last,
  input  logic        user,
  output logic [63:0] bytes,
  output logic [63:0] good,
  output logic [63:0] bad
);

  typedef enum logic [1:0] {IDLE, COUNT, SKIP} state_t;

  state_t               state, state_nxt;
  logic [len_width-1:0] len, len_nxt, fin_len;
  logic                 err, err_nxt, fin_err;
  logic                 commit;
  logic                 beat;

  assign beat = valid & ready;

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    err_nxt   = err;
    commit    = 1'b0;
    fin_len   = len;
    fin_err   = err;
    case (state)
      IDLE: begin
        if (beat) begin
          if (enable) begin
            len_nxt = len_width'(1);
            err_nxt = user;
            if (last) begin
              commit  = 1'b1;
              fin_len = len_width'(1);
              fin_err = user;
            end else begin
              state_nxt = COUNT;
            end
          end else if (!last) begin
            state_nxt = SKIP;
          end
        end
      end
      COUNT: begin
        if (beat) begin
          // Length saturates so an oversized frame reports the maximum rather than wrapping.
          len_nxt = (&len) ? len : len + len_width'(1);
          err_nxt = err | user;
          if (last) begin
            commit    = 1'b1;
            fin_len   = len_nxt;
            fin_err   = err_nxt;
            state_nxt = IDLE;
          end
        end
      end
      SKIP: begin
        if (beat && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= '0;
      err   <= 1'b0;
      bytes <= '0;
      good  <= '0;
      bad   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      err   <= err_nxt;
      if (commit) begin
        if (fin_err) begin
          bad <= bad + 64'd1;
        end else begin
          good  <= good + 64'd1;
          bytes <= bytes + 64'(fin_len);
        end
      end
    end
  end

endmodule

module eth_stats_counter #(
  parameter int len_width = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        tx_valid,
  input  logic        tx_ready,
  input  logic        tx_last,
  input  logic        tx_user,
  input  logic        rx_valid,
  input  logic        rx_ready,
  input  logic        rx_last,
  input  logic        rx_user,
  output logic [63:0] tx_bytes,
  output logic [63:0] tx_good,
  output logic [63:0] tx_bad,
  output logic [63:0] rx_bytes,
  output logic [63:0] rx_good,
  output logic [63:0] rx_bad
);

  eth_stats_dir #(.len_width(len_width)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .valid  (tx_valid),
    .ready  (tx_ready),
    .last   (tx_last),
    .user   (tx_user),
    .bytes  (tx_bytes),
    .good   (tx_good),
    .bad    (tx_bad)
  );

  eth_stats_dir #(.len_width(len_width)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .valid  (rx_valid),
    .ready  (rx_ready),
    .last   (rx_last),
    .user   (rx_user),
    .bytes  (rx_bytes),
    .good   (rx_good),
    .bad    (rx_bad)
  );

endmodule
